dot_mac_acc: RTL

Parametrised N-lane integer dot-product accumulator: the next generation of the fixed 4×8×8 MAC. Each accepted beat multiplies LANES pairs of DW-bit operands, reduces them through a pipelined adder tree and accumulates across a multi-beat group delimited by `in_last`. The block adds:
- signed/unsigned mode;
- saturating accumulation with a sticky flag;
- valid/ready backpressure on both sides.

It sits between the operand fetch stage and the result writeback in the vector MAC datapath.

---
 rtl/dot_mac_pkg.sv | 35 +++
 rtl/dot_mac_acc_if.sv | 31 +++
 rtl/dot_mac_tree.sv | 43 ++++
 rtl/dot_mac_acc.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/dot_mac_pkg.sv
// Shared types and helpers for the dot_mac_acc datapath.
// - Constant functions size the adder tree.
// - Clamp bounds are computed per group mode.
// - A small struct carries beat metadata down the pipeline.
package dot_mac_pkg;

  // Per-stage beat metadata: valid, operand mode, group-closing flag.
  typedef struct packed {
    logic valid;
    logic sgn;
    logic last;
  } beat_meta_t;

  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Tree sum width: product width, plus carry growth over LANES, plus a sign bit.
  function automatic int unsigned tree_w(input int unsigned dw, input int unsigned lanes);
    return 2 * dw + clog2_f(lanes) + 1;
  endfunction

  // Clamp bounds. These assume accw <= 62 so that they fit in a longint.
  function automatic longint sat_hi(input int unsigned accw, input logic sgn);
    return sgn ? (longint'(1) << (accw - 1)) - 1 : (longint'(1) << accw) - 1;
  endfunction

  function automatic longint sat_lo(input int unsigned accw, input logic sgn);
    return sgn ? -(longint'(1) << (accw - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/dot_mac_acc_if.sv
// Beat-in / result-out handshake bundle for dot_mac_acc.
// - master (fetch side and result consumer): drives beats and out_ready.
// - slave (dot_mac_acc): drives in_ready and the result fields.
interface dot_mac_acc_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACCW  = 32,
  parameter int unsigned BEATW = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*DW-1:0]   in_a;
  logic [LANES*DW-1:0]   in_b;
  logic                  in_signed;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [ACCW-1:0]       out_sum;
  logic                  out_sat;
  logic [BEATW-1:0]      out_beats;

  modport master (
    output in_valid, in_a, in_b, in_signed, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, out_beats
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_sat, out_beats
  );
endinterface

// File: rtl/dot_mac_tree.sv
// Registered LANES-input adder tree (pipeline stage S2).
// Ports:
// - clk, rst_n: clock and async active-low reset.
// - en: advance the stage; low while the output is stalled.
// - in_meta, prod: S1 metadata and LANES products of PW bits each.
// - out_meta, sum: registered metadata and the TW-bit extended sum.
module dot_mac_tree
  import dot_mac_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned PW    = 16,
  parameter int unsigned TW    = 19
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  beat_meta_t                in_meta,
  input  logic [LANES-1:0][PW-1:0]  prod,
  output beat_meta_t                out_meta,
  output logic [TW-1:0]             sum
);

  logic [TW-1:0] sum_d;

  // In unsigned mode the products are zero-extended, so a single adder serves both modes.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      sum_d = sum_d + {{(TW - PW){prod[i][PW-1] & in_meta.sgn}}, prod[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_meta <= '0;
      sum      <= '0;
    end else if (en) begin
      out_meta <= in_meta;
      if (in_meta.valid) sum <= sum_d;
    end
  end

endmodule

// File: rtl/dot_mac_acc.sv
// N-lane dot-product group accumulator with saturation and valid/ready flow control.
// Pipeline stages:
// - S1: lane multiplies.
// - S2: adder tree (dot_mac_tree).
// - S3: group accumulate and clamp.
// Ports:
// - clk, rst_n: clock and async active-low reset.
// - bus (slave): beat input in_* with in_ready; result output out_* with out_ready.
module dot_mac_acc
  import dot_mac_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACCW  = 32,
  parameter int unsigned BEATW = 16
) (
  input logic          clk,
  input logic          rst_n,
  dot_mac_acc_if.slave bus
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned TW = tree_w(DW, LANES);

  // The whole pipeline freezes while a result waits to be taken.
  logic stall, en;
  assign stall        = bus.out_valid & ~bus.out_ready;
  assign en           = ~stall;
  assign bus.in_ready = en;

  // S1: multipliers. Operands are extended to PW bits, so the truncated product is exact
  // in both modes.
  logic [LANES-1:0][PW-1:0] prod_d, prod_q;
  beat_meta_t               s1_d, s1_q;

  for (genvar i = 0; i < int'(LANES); i++) begin : g_lane
    logic [PW-1:0] a_ext, b_ext;
    assign a_ext     = {{DW{bus.in_a[i*DW+DW-1] & bus.in_signed}}, bus.in_a[i*DW +: DW]};
    assign b_ext     = {{DW{bus.in_b[i*DW+DW-1] & bus.in_signed}}, bus.in_b[i*DW +: DW]};
    assign prod_d[i] = a_ext * b_ext;
  end

  assign s1_d = '{valid: bus.in_valid, sgn: bus.in_signed, last: bus.in_last};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      prod_q <= '0;
    end else if (en) begin
      s1_q <= s1_d;
      if (bus.in_valid) prod_q <= prod_d;
    end
  end

  // S2: adder tree.
  beat_meta_t    s2_meta;
  logic [TW-1:0] tree_sum;

  dot_mac_tree #(
    .LANES (LANES),
    .PW    (PW),
    .TW    (TW)
  ) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_meta  (s1_q),
    .prod     (prod_q),
    .out_meta (s2_meta),
    .sum      (tree_sum)
  );

  // S3: accumulator state and registered outputs.
  logic [ACCW-1:0]  acc_q, acc_d, out_sum_q, out_sum_d, base, clamped;
  logic [BEATW-1:0] beats_q, beats_d, out_beats_q, out_beats_d, beats_base, beats_nxt;
  logic             first_q, first_d, sat_q, sat_d, mode_q, mode_d;
  logic             out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic             grp_sgn, clamp, sat_new;
  logic [ACCW:0]    base_x, tree_x, nxt;
  longint           nxt_l, hi, lo;

  always_comb begin
    // The group mode comes from the group's first beat.
    grp_sgn    = first_q ? s2_meta.sgn : mode_q;
    base       = first_q ? '0 : acc_q;
    base_x     = {grp_sgn & base[ACCW-1], base};
    tree_x     = {{(ACCW + 1 - TW){grp_sgn & tree_sum[TW-1]}}, tree_sum};
    nxt        = base_x + tree_x;
    if (grp_sgn) nxt_l = longint'($signed(nxt));
    else         nxt_l = longint'(nxt);
    hi         = sat_hi(ACCW, grp_sgn);
    lo         = sat_lo(ACCW, grp_sgn);
    clamp      = 1'b0;
    clamped    = nxt[ACCW-1:0];
    if (nxt_l > hi) begin
      clamp   = 1'b1;
      clamped = ACCW'(hi);
    end else if (nxt_l < lo) begin
      clamp   = 1'b1;
      clamped = ACCW'(lo);
    end
    sat_new    = (first_q ? 1'b0 : sat_q) | clamp;
    beats_base = first_q ? '0 : beats_q;
    beats_nxt  = (&beats_base) ? beats_base : beats_base + 1'b1;

    acc_d       = acc_q;
    sat_d       = sat_q;
    beats_d     = beats_q;
    first_d     = first_q;
    mode_d      = mode_q;
    out_sum_d   = out_sum_q;
    out_sat_d   = out_sat_q;
    out_beats_d = out_beats_q;
    // A taken result drops out_valid unless a new last beat refills it below.
    out_valid_d = out_valid_q & ~bus.out_ready;

    if (en && s2_meta.valid) begin
      acc_d   = clamped;
      sat_d   = sat_new;
      beats_d = beats_nxt;
      mode_d  = grp_sgn;
      first_d = 1'b0;
      if (s2_meta.last) begin
        out_sum_d   = clamped;
        out_sat_d   = sat_new;
        out_beats_d = beats_nxt;
        out_valid_d = 1'b1;
        first_d     = 1'b1;
        sat_d       = 1'b0;
        beats_d     = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      sat_q       <= 1'b0;
      beats_q     <= '0;
      first_q     <= 1'b1;
      mode_q      <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
      out_beats_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      sat_q       <= sat_d;
      beats_q     <= beats_d;
      first_q     <= first_d;
      mode_q      <= mode_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
      out_beats_q <= out_beats_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_beats = out_beats_q;

endmodule
